// File: rtl/slow_clock_monitor.sv
// Slow-clock monitor: synchronises a divided clock, emits edge ticks, measures period, tracks lock/loss.
// Optional high-time measurement is enabled by defining DUTY_MEASURE_EN.
module slow_clock_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned TOL         = 2,
  parameter int unsigned LOCK_COUNT  = 3,
  parameter int unsigned TIMEOUT     = 60000000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             slow_clk,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
`ifdef DUTY_MEASURE_EN
  ,
  output logic [CNT_W-1:0] high_time
`endif
);

  localparam int unsigned MW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    LOCK_C    = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d_q, rise, fall;
  logic [CNT_W-1:0]       cnt_q, cnt_d, period_q, period_d, diff;
  logic [MW-1:0]          match_q, match_d, match_inc;
  logic                   prev_ok_q, prev_ok_d, is_match;
  logic                   rise_tick_q, fall_tick_q, period_valid_q, period_valid_d;
  logic                   locked_q, lost_q;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  // Unsigned absolute difference between the interval just ending and the stored period.
  assign diff      = (cnt_q >= period_q) ? (cnt_q - period_q) : (period_q - cnt_q);
  assign is_match  = prev_ok_q && (diff <= TOL_C);
  assign match_inc = (&match_q) ? match_q : match_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = rise ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
    period_d       = period_q;
    period_valid_d = 1'b0;
    match_d        = match_q;
    prev_ok_d      = prev_ok_q;
    case (state_q)
      IDLE, LOST: begin
        if (rise) begin
          state_d   = ACQUIRE;
          prev_ok_d = 1'b0;
          match_d   = '0;
        end
      end
      ACQUIRE, LOCKED: begin
        // A rise in the same cycle as the timeout threshold takes priority.
        if (rise) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          prev_ok_d      = 1'b1;
          match_d        = is_match ? match_inc : '0;
          if (state_q == ACQUIRE) begin
            if (match_d >= LOCK_C) state_d = LOCKED;
          end else if (!is_match) begin
            state_d = ACQUIRE;
          end
        end else if (cnt_q >= TIMEOUT_C) begin
          state_d = LOST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= IDLE;
      sync_q         <= '0;
      s_d_q          <= 1'b0;
      cnt_q          <= '0;
      period_q       <= '0;
      match_q        <= '0;
      prev_ok_q      <= 1'b0;
      rise_tick_q    <= 1'b0;
      fall_tick_q    <= 1'b0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      s_d_q          <= s;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      match_q        <= match_d;
      prev_ok_q      <= prev_ok_d;
      rise_tick_q    <= rise;
      fall_tick_q    <= fall;
      period_valid_q <= period_valid_d;
      locked_q       <= (state_q == LOCKED);
      lost_q         <= (state_q == LOST);
    end
  end

`ifdef DUTY_MEASURE_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d, high_time_q;

  always_comb begin
    hcnt_d = hcnt_q;
    if (rise)                 hcnt_d = CNT_W'(1);
    else if (s && !(&hcnt_q)) hcnt_d = hcnt_q + 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hcnt_q      <= '0;
      high_time_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      if (period_valid_d) high_time_q <= hcnt_q;
    end
  end

  assign high_time = high_time_q;
`endif

  assign rise_tick    = rise_tick_q;
  assign fall_tick    = fall_tick_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign lost         = lost_q;

endmodule
